sqrt_iterative: RTL
===================

Name: sqrt_iterative

Overview:
- Multi-cycle unsigned integer square root with valid/ready handshakes on input and output.
- Parametrised operand width and bits-resolved-per-cycle; optional round-to-nearest; exports the remainder.
- Sits after the I²+Q² power stage in the absolute-value path and replaces the single-cycle unrolled root.

Parameters:
- IN_WIDTH, 142, radicand width; must be even, ≥4.
- BITS_PER_CYCLE, 1, root bits resolved per clock; 1..IN_WIDTH/2.
- ROUND, 0, 0 = floor(sqrt), 1 = round-to-nearest.
- Derived: HALF = IN_WIDTH/2; ITER = ceil(HALF/BITS_PER_CYCLE); OUT_WIDTH = HALF+ROUND; REM_WIDTH = HALF+1.

Ports:
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- inValid  in  1  inputData valid
- inReady  out  1  block can accept a radicand
- inputData  in  IN_WIDTH  unsigned radicand x
- outValid  out  1  result valid
- outReady  in  1  downstream accepts the result
- outputData  out  OUT_WIDTH  root (floor or rounded)
- remainder  out  REM_WIDTH  x − floor(sqrt(x))², always the floor remainder

Behaviour:
- Reset (resetN=0, asynchronous): state=IDLE; inReady=1; outValid=0; outputData=0; remainder=0; all internal registers 0. Assertion mid-CALC or mid-DONE discards the operation. No output is produced for it after release.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - inReady=1.
  - An edge with inValid=1 latches inputData, zero-extended at the MSB to 2·ITER·BITS_PER_CYCLE bits.
  - The same edge clears partial root, remainder and iteration counter, and moves to CALC.
- CALC:
  - inReady=0.
  - Each edge performs BITS_PER_CYCLE restoring digit steps, MSB first:
    - shift the next 2 radicand bits into the partial remainder;
    - trial = remainder − {root,01};
    - if trial ≥ 0, remainder = trial and root bit = 1;
    - else root bit = 0.
  - The counter increments each edge. After ITER edges the block enters DONE.
- Latency: outValid rises on the ITER-th edge after the accepting edge. Defaults give 71 cycles; BITS_PER_CYCLE=4 gives 18.
- Rounding (ROUND=1): applied on the final CALC edge. outputData = root+1 if remainder > root, else root. For x = 2^IN_WIDTH−1 this yields 2^HALF; OUT_WIDTH holds it without overflow.
- DONE:
  - outValid=1; outputData and remainder are stable and held.
  - Leaves DONE on the first edge with outReady=1. That edge sets outValid=0 and returns to IDLE.
  - inReady stays 0 throughout DONE. The next operand is accepted no earlier than one cycle after output handoff.
  - Throughput: one result per ITER+2 cycles with outReady held high.
- Widths: trial subtraction is REM_WIDTH+1 bits with sign at the MSB. The final remainder is ≤ 2·root, so it fits REM_WIDTH.
- x=0 gives root 0, remainder 0, with the same latency. Latency never depends on data.
- inValid while inReady=0 is ignored; the upstream holds its data.
- outputData and remainder are undefined-free: they hold their last values or 0 outside DONE. Only outValid qualifies them.

Decomposition:
- Shared package sqrt_pkg:
  - state encoding (IDLE, CALC, DONE);
  - helper function ceil_div;
  - derived-width constants computed from IN_WIDTH and BITS_PER_CYCLE.
- Natural sub-module: sqrt_digit_step. It is combinational: one restoring step (remainder, root, 2 radicand bits in; updated remainder and root out).
- The top instantiates sqrt_digit_step BITS_PER_CYCLE times in a generate chain. The top owns the FSM, counter and handshake registers.

Test Plan:
- Defaults; x=99 → after 71 cycles outValid=1, outputData=9, remainder=18. With ROUND=1: outputData=10. x=90 with ROUND=1 → 9, remainder=9.
- x=0 and x=2^142−1 → root 0 / rem 0; root 2^71−1 / rem 2^72−2. With ROUND=1, max input → 2^71.
- BITS_PER_CYCLE=4, IN_WIDTH=16; sweep all 65536 inputs against a reference model:
  - outValid exactly 2 cycles after accept (ITER=2);
  - root² ≤ x < (root+1)²; remainder matches.
- Backpressure: outReady=0 for 10 cycles after outValid → outputData/remainder/outValid held and inReady=0. inValid pulses during that window are ignored. Raising outReady for one cycle → IDLE next edge, next operand accepted.
- Reset mid-CALC (resetN low at cycle 30 of 71, asynchronous to the edge) → outValid=0 and inReady=1 immediately. No stale result appears. A fresh x=144 after release returns 12, rem 0, 71 cycles later.
- Back-to-back stream of 8 random 142-bit values with inValid and outReady tied high → results in order, spaced ITER+2 cycles, all matching the model.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root block: FSM encoding and
// helpers that derive the internal widths from the radicand width and the
// number of root bits resolved per clock.
package sqrt_pkg;

  // Controller states: waiting for an operand, iterating, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrtState_t;

  // Integer ceiling division for elaboration-time width arithmetic.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 32'sd1) / den;
  endfunction

  // Number of root bits for a radicand of the given width.
  function automatic int half_width(input int inWidth);
    return inWidth / 32'sd2;
  endfunction

  // Clock edges needed to resolve all root bits.
  function automatic int iter_count(input int inWidth, input int bitsPerCycle);
    return ceil_div(half_width(inWidth), bitsPerCycle);
  endfunction

  // Root register width: whole groups of bitsPerCycle, so it may exceed HALF
  // when bitsPerCycle does not divide HALF (the extra MSBs stay zero).
  function automatic int root_width(input int inWidth, input int bitsPerCycle);
    return iter_count(inWidth, bitsPerCycle) * bitsPerCycle;
  endfunction

  // Radicand shift register width: two radicand bits per root bit, with
  // zero padding at the MSB end to fill whole iterations.
  function automatic int pad_width(input int inWidth, input int bitsPerCycle);
    return 32'sd2 * root_width(inWidth, bitsPerCycle);
  endfunction

  // Iteration counter width; at least one bit even for a single iteration.
  function automatic int cnt_width(input int inWidth, input int bitsPerCycle);
    int iter;
    iter = iter_count(inWidth, bitsPerCycle);
    return (iter > 32'sd1) ? $clog2(iter) : 32'sd1;
  endfunction

endpackage

// File: rtl/sqrt_digit_step.sv
// One restoring square-root digit step (combinational).
// The next two radicand bits are shifted into the partial remainder, the
// trial value {root,01} is subtracted if it fits, and the new root bit
// records whether it did.
module sqrt_digit_step #(
  parameter int REM_WIDTH  = 72,
  parameter int ROOT_WIDTH = 71
) (
  input  logic [REM_WIDTH-1:0]  remIn,
  input  logic [ROOT_WIDTH-1:0] rootIn,
  input  logic [1:0]            radBits,
  output logic [REM_WIDTH-1:0]  remOut,
  output logic [ROOT_WIDTH-1:0] rootOut
);

  // Wide enough that neither operand of the trial subtraction is truncated,
  // so the full-width comparison is exactly the sign of the trial result.
  localparam int CMP_WIDTH = ((REM_WIDTH > ROOT_WIDTH) ? REM_WIDTH : ROOT_WIDTH) + 2;

  logic [CMP_WIDTH-1:0] shifted;
  logic [CMP_WIDTH-1:0] trialSub;
  logic [REM_WIDTH-1:0] diff;
  logic                 fits;

  // Trial subtraction and restore decision for one root bit.
  always_comb begin
    shifted  = CMP_WIDTH'({remIn, radBits});
    trialSub = CMP_WIDTH'({rootIn, 2'b01});
    fits     = (shifted >= trialSub);
    // A non-negative trial is at most 2*newRoot, so the low REM_WIDTH bits
    // of the difference carry the whole value.
    diff     = shifted[REM_WIDTH-1:0] - trialSub[REM_WIDTH-1:0];
    if (fits) begin
      remOut  = diff;
      rootOut = {rootIn[ROOT_WIDTH-2:0], 1'b1};
    end else begin
      remOut  = shifted[REM_WIDTH-1:0];
      rootOut = {rootIn[ROOT_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_iterative.sv
// Multi-cycle unsigned integer square root with valid/ready handshakes.
// Resolves BITS_PER_CYCLE root bits per clock through a chain of restoring
// digit steps; optionally rounds to nearest and always exports the floor
// remainder x - floor(sqrt(x))^2. Latency is ITER edges regardless of data.
module sqrt_iterative
  import sqrt_pkg::*;
#(
  parameter int IN_WIDTH       = 142,
  parameter int BITS_PER_CYCLE = 1,
  parameter int ROUND          = 0
) (
  input  logic                        clock,
  input  logic                        resetN,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [IN_WIDTH-1:0]         inputData,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [IN_WIDTH/2+ROUND-1:0] outputData,
  output logic [IN_WIDTH/2:0]         remainder
);

  localparam int HALF       = half_width(IN_WIDTH);
  localparam int ITER       = iter_count(IN_WIDTH, BITS_PER_CYCLE);
  localparam int OUT_WIDTH  = HALF + ROUND;
  localparam int REM_WIDTH  = HALF + 1;
  localparam int ROOT_WIDTH = root_width(IN_WIDTH, BITS_PER_CYCLE);
  localparam int PAD_WIDTH  = pad_width(IN_WIDTH, BITS_PER_CYCLE);
  localparam int CNT_WIDTH  = cnt_width(IN_WIDTH, BITS_PER_CYCLE);
  localparam int STEP_SHIFT = 2 * BITS_PER_CYCLE;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ITER - 1);
  localparam bit                   ROUND_EN = (ROUND != 0);

  sqrtState_t            state;
  logic [PAD_WIDTH-1:0]  radReg;
  logic [ROOT_WIDTH-1:0] rootReg;
  logic [REM_WIDTH-1:0]  remReg;
  logic [CNT_WIDTH-1:0]  iterCnt;

  logic [ROOT_WIDTH-1:0] stepRoot;
  logic [REM_WIDTH-1:0]  stepRem;
  logic [OUT_WIDTH-1:0]  resultRoot;

  // Digit-step chain: stage g consumes radicand bit pair g counted from the
  // MSB of the shift register, so one clock resolves BITS_PER_CYCLE bits.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : gStep
    logic [REM_WIDTH-1:0]  remI;
    logic [REM_WIDTH-1:0]  remO;
    logic [ROOT_WIDTH-1:0] rootI;
    logic [ROOT_WIDTH-1:0] rootO;

    if (g == 0) begin : gFirst
      assign remI  = remReg;
      assign rootI = rootReg;
    end else begin : gNext
      assign remI  = gStep[g-1].remO;
      assign rootI = gStep[g-1].rootO;
    end

    sqrt_digit_step #(
      .REM_WIDTH (REM_WIDTH),
      .ROOT_WIDTH(ROOT_WIDTH)
    ) uStep (
      .remIn  (remI),
      .rootIn (rootI),
      .radBits(radReg[PAD_WIDTH-1-2*g -: 2]),
      .remOut (remO),
      .rootOut(rootO)
    );
  end

  assign stepRoot = gStep[BITS_PER_CYCLE-1].rootO;
  assign stepRem  = gStep[BITS_PER_CYCLE-1].remO;

  // Round-to-nearest on the final root: x lies above (r+0.5)^2 exactly when
  // the floor remainder exceeds r. OUT_WIDTH has one spare bit for 2^HALF.
  always_comb begin
    if (ROUND_EN && (stepRem > REM_WIDTH'(stepRoot))) begin
      resultRoot = OUT_WIDTH'(stepRoot) + {{(OUT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      resultRoot = OUT_WIDTH'(stepRoot);
    end
  end

  // Controller FSM with all handshake and result registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      radReg     <= '0;
      rootReg    <= '0;
      remReg     <= '0;
      iterCnt    <= '0;
      inReady    <= 1'b1;
      outValid   <= 1'b0;
      outputData <= '0;
      remainder  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            radReg  <= PAD_WIDTH'(inputData);
            rootReg <= '0;
            remReg  <= '0;
            iterCnt <= '0;
            inReady <= 1'b0;
            state   <= CALC;
          end else begin
            inReady <= 1'b1;
          end
        end
        CALC: begin
          radReg  <= radReg << STEP_SHIFT;
          rootReg <= stepRoot;
          remReg  <= stepRem;
          if (iterCnt == LAST_CNT) begin
            iterCnt    <= '0;
            outputData <= resultRoot;
            remainder  <= stepRem;
            outValid   <= 1'b1;
            state      <= DONE;
          end else begin
            iterCnt <= iterCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          // Result and remainder hold until the downstream takes them; the
          // next operand is only accepted from IDLE, one cycle later.
          if (outReady) begin
            outValid <= 1'b0;
            inReady  <= 1'b1;
            state    <= IDLE;
          end else begin
            outValid <= 1'b1;
          end
        end
        default: begin
          outValid <= 1'b0;
          inReady  <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
